// File: rtl/sort_result_monitor.sv
// Watches the core's three result registers until they settle, snapshots them,
// checks ascending order and streams the snapshot out over valid/ready.
module sort_result_monitor #(
  parameter int DATA_W         = 64,
  parameter int STABLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int SIGNED_CMP     = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] element1,
  input  logic [DATA_W-1:0] element2,
  input  logic [DATA_W-1:0] element3,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_index,
  output logic              done,
  output logic              pass,
  output logic              timeout
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {WATCH, STREAM, DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  stableCnt_q, stableCnt_d;
  logic [CNT_W-1:0]  timeoutCnt_q, timeoutCnt_d;
  logic              snapValid_q, snapValid_d;
  logic [DATA_W-1:0] snap1_q, snap1_d, snap2_q, snap2_d, snap3_q, snap3_d;
  logic [DATA_W-1:0] hold1_q, hold1_d, hold2_q, hold2_d;
  logic              outValid_q, outValid_d;
  logic [DATA_W-1:0] outData_q, outData_d;
  logic [1:0]        outIndex_q, outIndex_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              timeout_q, timeout_d;

  logic inputsMatch;
  logic stableHit;
  logic ordered;

  function automatic logic lessEq(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    if (SIGNED_CMP != 0) return ($signed(a) <= $signed(b));
    return (a <= b);
  endfunction

  // hold[0] is never needed again after the transition: it goes straight into out_data.
  assign inputsMatch = snapValid_q && (element1 == snap1_q) && (element2 == snap2_q) &&
                       (element3 == snap3_q);
  assign stableHit   = inputsMatch && (stableCnt_q == CNT_W'(STABLE_CYCLES - 1));
  assign ordered     = lessEq(element1, element2) && lessEq(element2, element3);

  always_comb begin
    state_d      = state_q;
    stableCnt_d  = stableCnt_q;
    timeoutCnt_d = timeoutCnt_q;
    snapValid_d  = snapValid_q;
    snap1_d      = snap1_q;
    snap2_d      = snap2_q;
    snap3_d      = snap3_q;
    hold1_d      = hold1_q;
    hold2_d      = hold2_q;
    outValid_d   = outValid_q;
    outData_d    = outData_q;
    outIndex_d   = outIndex_q;
    done_d       = done_q;
    pass_d       = pass_q;
    timeout_d    = timeout_q;

    case (state_q)
      WATCH: begin
        snap1_d      = element1;
        snap2_d      = element2;
        snap3_d      = element3;
        snapValid_d  = 1'b1;
        timeoutCnt_d = timeoutCnt_q + 1'b1;
        stableCnt_d  = inputsMatch ? stableCnt_q + 1'b1 : '0;
        // Stability takes priority over a timeout landing on the same cycle.
        if (stableHit) begin
          state_d    = STREAM;
          hold1_d    = element2;
          hold2_d    = element3;
          pass_d     = ordered;
          outValid_d = 1'b1;
          outIndex_d = 2'd0;
          outData_d  = element1;
        end else if (timeoutCnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d   = DONE;
          done_d    = 1'b1;
          timeout_d = 1'b1;
          pass_d    = 1'b0;
        end
      end
      STREAM: begin
        if (outValid_q && out_ready) begin
          if (outIndex_q == 2'd2) begin
            state_d    = DONE;
            outValid_d = 1'b0;
            done_d     = 1'b1;
          end else begin
            outIndex_d = outIndex_q + 2'd1;
            outData_d  = (outIndex_q == 2'd0) ? hold1_q : hold2_q;
          end
        end
      end
      DONE: begin
      end
      default: state_d = WATCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= WATCH;
      stableCnt_q  <= '0;
      timeoutCnt_q <= '0;
      snapValid_q  <= 1'b0;
      snap1_q      <= '0;
      snap2_q      <= '0;
      snap3_q      <= '0;
      hold1_q      <= '0;
      hold2_q      <= '0;
      outValid_q   <= 1'b0;
      outData_q    <= '0;
      outIndex_q   <= 2'd0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      stableCnt_q  <= stableCnt_d;
      timeoutCnt_q <= timeoutCnt_d;
      snapValid_q  <= snapValid_d;
      snap1_q      <= snap1_d;
      snap2_q      <= snap2_d;
      snap3_q      <= snap3_d;
      hold1_q      <= hold1_d;
      hold2_q      <= hold2_d;
      outValid_q   <= outValid_d;
      outData_q    <= outData_d;
      outIndex_q   <= outIndex_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      timeout_q    <= timeout_d;
    end
  end

  assign out_valid = outValid_q;
  assign out_data  = outData_q;
  assign out_index = outIndex_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_sort_result_monitor.sv
// Scoreboard bench for sort_result_monitor: stimulus pushes expected beats,
// a negedge monitor pops and compares every accepted beat.
module tb_sort_result_monitor;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] element1, element2, element3;
  logic         out_ready;

  logic         outValid, done, pass, timeout;
  logic [W-1:0] outData;
  logic [1:0]   outIndex;
  logic         outValidU, doneU, passU, timeoutU;
  logic [W-1:0] outDataU;
  logic [1:0]   outIndexU;

  int total = 0;
  int bad = 0;
  int beatCount = 0;
  int baseCount = 0;

  typedef struct packed {
    logic [1:0]   idx;
    logic [W-1:0] data;
  } beat_t;
  beat_t expQ[$];

  always #5 clk = ~clk;

  sort_result_monitor #(.DATA_W(W), .STABLE_CYCLES(4), .TIMEOUT_CYCLES(32), .SIGNED_CMP(1)) dut (
    .clk(clk), .reset(reset), .element1(element1), .element2(element2), .element3(element3),
    .out_ready(out_ready), .out_valid(outValid), .out_data(outData), .out_index(outIndex),
    .done(done), .pass(pass), .timeout(timeout)
  );

  // Unsigned twin sees identical stimulus; only its ordering verdict differs.
  sort_result_monitor #(.DATA_W(W), .STABLE_CYCLES(4), .TIMEOUT_CYCLES(32), .SIGNED_CMP(0)) dutU (
    .clk(clk), .reset(reset), .element1(element1), .element2(element2), .element3(element3),
    .out_ready(out_ready), .out_valid(outValidU), .out_data(outDataU), .out_index(outIndexU),
    .done(doneU), .pass(passU), .timeout(timeoutU)
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [W-1:0] e1, input logic [W-1:0] e2, input logic [W-1:0] e3);
    element1 = e1;
    element2 = e2;
    element3 = e3;
  endtask

  task automatic pushBeats(input logic [W-1:0] d0, input logic [W-1:0] d1, input logic [W-1:0] d2);
    beat_t b;
    b.idx = 2'd0; b.data = d0; expQ.push_back(b);
    b.idx = 2'd1; b.data = d1; expQ.push_back(b);
    b.idx = 2'd2; b.data = d2; expQ.push_back(b);
  endtask

  // Caller sits just after a rising edge; reset is sampled low on the next edge.
  task automatic doReset();
    reset = 1'b0;
    @(posedge clk); #1;
    check("rstValid", outValid, 0);
    check("rstData", outData, 0);
    check("rstIndex", outIndex, 0);
    check("rstDone", done, 0);
    check("rstPass", pass, 0);
    check("rstTimeout", timeout, 0);
    expQ.delete();
    baseCount = beatCount;
    reset = 1'b1;
  endtask

  task automatic waitDone(input int maxCycles);
    int n = 0;
    while (done !== 1'b1 && n < maxCycles) begin
      @(posedge clk); #1;
      n++;
    end
    check("doneWait", done, 1);
  endtask

  task automatic checkOutput(input logic expDone, input logic expPass, input logic expTimeout,
                             input logic expPassU, input int expBeats);
    check("done", done, expDone);
    check("pass", pass, expPass);
    check("timeout", timeout, expTimeout);
    check("validAfterDone", outValid, 0);
    check("passUnsigned", passU, expPassU);
    check("beatCount", beatCount - baseCount, expBeats);
    check("queueDrained", expQ.size(), 0);
  endtask

  // Monitor: compares accepted beats and checks that a stalled beat stays put.
  initial begin
    logic         stalled;
    logic [W-1:0] stallData;
    logic [1:0]   stallIdx;
    beat_t        b;
    stalled = 1'b0;
    stallData = '0;
    stallIdx = 2'd0;
    forever begin
      @(negedge clk);
      if (reset !== 1'b1) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          check("stallValid", outValid, 1);
          check("stallData", outData, stallData);
          check("stallIndex", outIndex, stallIdx);
        end
        stalled = outValid && !out_ready;
        stallData = outData;
        stallIdx = outIndex;
        if (outValid && out_ready) begin
          beatCount++;
          if (expQ.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpectedBeat: got index=%0d data=%0h expected no beat", outIndex, outData);
          end else begin
            b = expQ.pop_front();
            check("beatIndex", outIndex, b.idx);
            check("beatData", outData, b.data);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b0;
    out_ready = 1'b1;
    applyStimulus(64'd5, 64'd7, 64'd9);

    $display("[TB] stable sorted input, cycle-exact");
    doReset();
    pushBeats(64'd5, 64'd7, 64'd9);
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("validCycle%0d", k + 1), outValid, (k >= 4 && k <= 6));
      check($sformatf("doneCycle%0d", k + 1), done, (k >= 7));
    end
    @(posedge clk); #1;
    checkOutput(1, 1, 0, 1, 3);

    $display("[TB] unsorted input");
    applyStimulus(64'd9, 64'd3, 64'd7);
    doReset();
    pushBeats(64'd9, 64'd3, 64'd7);
    waitDone(60);
    checkOutput(1, 0, 0, 0, 3);

    $display("[TB] signed compare");
    applyStimulus(64'hFFFF_FFFF_FFFF_FFFE, 64'd0, 64'd1);
    doReset();
    pushBeats(64'hFFFF_FFFF_FFFF_FFFE, 64'd0, 64'd1);
    waitDone(60);
    checkOutput(1, 1, 0, 0, 3);

    $display("[TB] changing inputs and backpressure");
    out_ready = 1'b0;
    applyStimulus(64'd1, 64'd2, 64'd3);
    doReset();
    pushBeats(64'd1, 64'd2, 64'd3);
    for (int i = 0; i < 23; i++) begin
      @(posedge clk); #1;
      if (i < 20 && (i % 3) == 2) element2 = (element2 == 64'd2) ? 64'd8 : 64'd2;
      @(negedge clk);
      check($sformatf("settleValid%0d", i), outValid, (i == 22));
    end
    repeat (3) @(posedge clk);
    #1 out_ready = 1'b1;
    waitDone(60);
    checkOutput(1, 1, 0, 1, 3);

    $display("[TB] timeout");
    applyStimulus(64'd100, 64'd200, 64'd300);
    doReset();
    for (int k = 0; k < 32; k++) begin
      @(posedge clk); #1;
      element1 = element1 + 64'd1;
      @(negedge clk);
      check($sformatf("tmoDone%0d", k), done, (k == 31));
      check($sformatf("tmoFlag%0d", k), timeout, (k == 31));
    end
    @(posedge clk); #1;
    checkOutput(1, 0, 1, 0, 0);

    $display("[TB] reset mid-stream");
    applyStimulus(64'd4, 64'd6, 64'd8);
    doReset();
    pushBeats(64'd4, 64'd6, 64'd8);
    begin
      int n = 0;
      while ((beatCount - baseCount) < 2 && n < 60) begin
        @(posedge clk); #1;
        n++;
      end
    end
    check("midCount", beatCount - baseCount, 2);
    doReset();
    pushBeats(64'd4, 64'd6, 64'd8);
    waitDone(60);
    checkOutput(1, 1, 0, 1, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
